// File: rtl/alu_pkg.sv
// Shared definitions for the 32-bit ALU: datapath width and opcode encoding.
package alu_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned OP_W  = 3;

    // Bit 2 selects the inverted B operand with carry-in 1 (ANDN/ORN/SUB/SLT).
    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_ADD  = 3'b010,
        OP_RSVD = 3'b011,
        OP_ANDN = 3'b100,
        OP_ORN  = 3'b101,
        OP_SUB  = 3'b110,
        OP_SLT  = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU datapath with one shared adder.
// Ports:
//   a, b   : operands, two's complement
//   f      : operation select (alu_op_e encoding)
//   res_c  : combinational result
module alu_comb
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  f,
    output logic [WIDTH-1:0] res_c
);

    logic [WIDTH-1:0] b_mux;
    logic [WIDTH-1:0] sum;
    logic             ovf;
    logic             slt;
    alu_op_e          op;

    // f[2] inverts B and injects carry-in, turning the adder into a subtractor.
    assign b_mux = f[2] ? ~b : b;
    assign sum   = a + b_mux + WIDTH'(f[2]);

    // Signed overflow of a-b: operands of equal sign yielding a result of the other sign.
    assign ovf = (a[WIDTH-1] == b_mux[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign slt = sum[WIDTH-1] ^ ovf;

    assign op = alu_op_e'(f);

    // Result select.
    always_comb begin
        res_c = '0;
        case (op)
            OP_AND:  res_c = a & b_mux;
            OP_OR:   res_c = a | b_mux;
            OP_ADD:  res_c = sum;
            OP_RSVD: res_c = '0;
            OP_ANDN: res_c = a & b_mux;
            OP_ORN:  res_c = a | b_mux;
            OP_SUB:  res_c = sum;
            OP_SLT:  res_c = WIDTH'(slt);
            default: res_c = '0;
        endcase
    end

endmodule

// File: rtl/alu_32bit.sv
// 32-bit ALU with a registered result, zero flag and valid, latency one cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : a, b, f captured on this rising edge
//   a, b, f    : operands and operation select
//   y, z       : registered result and zero flag (held while idle)
//   out_valid  : one-cycle pulse when y/z carry a new result
module alu_32bit
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  f,
    output logic [WIDTH-1:0] y,
    output logic             z,
    output logic             out_valid
);

    logic [WIDTH-1:0] res_c;

    alu_comb u_comb (
        .a     (a),
        .b     (b),
        .f     (f),
        .res_c (res_c)
    );

    // Output register: load on in_valid, otherwise hold; z tracks the loaded result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y         <= '0;
            z         <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y <= res_c;
                z <= ~|res_c;
            end
        end
    end

endmodule

// File: tb/tb_alu_32bit.sv
// Scoreboard bench for alu_32bit: directed vectors, streaming, mid-stream
// reset and randomized operations against a behavioural reference model.
module tb_alu_32bit;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b1;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic [2:0]  f = 3'b010;
    logic [31:0] y;
    logic        z;
    logic        out_valid;

    typedef struct packed {
        logic [31:0] y;
        logic        z;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] hold_y = 32'h0;
    logic        hold_z = 1'b1;

    alu_32bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .f         (f),
        .y         (y),
        .z         (z),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Reference model: operation semantics from plain arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] w);
        case (op)
            3'd0: return x & w;
            3'd1: return x | w;
            3'd2: return x + w;
            3'd3: return 32'h0;
            3'd4: return x & ~w;
            3'd5: return x | ~w;
            3'd6: return x - w;
            default: return ($signed(x) < $signed(w)) ? 32'h1 : 32'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one operation with an explicit expected result, then scramble inputs after the edge.
    task automatic issue_exp(input logic [2:0] op, input logic [31:0] x, input logic [31:0] w,
                             input logic [31:0] exp_y);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        a = x;
        b = w;
        f = op;
        e.y = exp_y;
        e.z = (exp_y == 32'h0);
        q.push_back(e);
        @(posedge clk);
        #3;
        a = $urandom;
        b = $urandom;
        f = 3'($urandom);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] w);
        issue_exp(op, x, w, model(op, x, w));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            a = $urandom;
            b = $urandom;
            f = 3'($urandom);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pops the scoreboard on out_valid, otherwise checks held outputs.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            check("reset_y", y, 32'h0);
            check("reset_z", 32'(z), 32'h1);
            check("reset_out_valid", 32'(out_valid), 32'h0);
            hold_y = 32'h0;
            hold_z = 1'b1;
        end else if (out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_valid: got out_valid=1 expected no pending result at %0t", $time);
            end else begin
                e = q.pop_front();
                check("result_y", y, e.y);
                check("result_z", 32'(z), 32'(e.z));
                hold_y = e.y;
                hold_z = e.z;
            end
        end else begin
            check("held_y", y, hold_y);
            check("held_z", 32'(z), 32'(hold_z));
            check("pending_results", 32'(q.size()), 32'h0);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish by 200000");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held with in_valid=1, then release with outputs holding.
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        idle(2);

        // ADD
        issue_exp(3'b010, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
        issue_exp(3'b010, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000);
        issue_exp(3'b010, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100);
        // SUB
        issue_exp(3'b110, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001);
        issue_exp(3'b110, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000);
        issue_exp(3'b110, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF);
        idle(1);
        // SLT
        issue_exp(3'b111, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
        issue_exp(3'b111, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001);
        issue_exp(3'b111, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        issue_exp(3'b111, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
        issue_exp(3'b111, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001);
        issue_exp(3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000);
        // Logic ops and reserved
        issue_exp(3'b000, 32'h1234_5678, 32'h8765_4321, 32'h0224_4220);
        issue_exp(3'b001, 32'h1234_5678, 32'h8765_4321, 32'h9775_5779);
        issue_exp(3'b001, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
        issue_exp(3'b100, 32'hFFFF_FFFF, 32'h1234_5678, 32'hEDCB_A987);
        issue_exp(3'b101, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        issue_exp(3'b011, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000);
        idle(2);

        // Streaming: three different ops back to back, then idle with y held.
        issue_exp(3'b010, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030);
        issue_exp(3'b110, 32'h0000_0010, 32'h0000_0020, 32'hFFFF_FFF0);
        issue_exp(3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
        idle(3);

        // Mid-stream asynchronous reset: outputs clear without a clock edge.
        issue_exp(3'b001, 32'hA5A5_0000, 32'h0000_5A5A, 32'hA5A5_5A5A);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        #1;
        check("async_reset_y", y, 32'h0);
        check("async_reset_z", 32'(z), 32'h1);
        check("async_reset_out_valid", 32'(out_valid), 32'h0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        idle(2);

        // Randomized traffic with idle gaps.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0)
                idle(1);
            else
                issue(3'($urandom), pick_operand(), pick_operand());
        end
        idle(3);
        check("final_pending", 32'(q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
